// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: FSM state encoding,
// default playfield geometry and coordinate widths.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int DEF_BIRD_X    = 100;
    localparam int DEF_BIRD_SIZE = 16;
    localparam int DEF_PIPE_W    = 40;
    localparam int DEF_GAP_HALF  = 60;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_HIT_HOLD  = 60;

    localparam int COORD_W = 10;
    localparam int SUM_W   = 11;

    localparam logic [11:0] BCD_MAX = 12'h999;

    // Single BCD digit step; carry is raised when the digit wraps 9 -> 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit);
        logic [4:0] result;
        if (digit == 4'd9) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD score register with synchronous clear and a
// saturating increment that stops at 999.
module bcd_counter3
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [11:0] count
);

    logic [11:0] count_q;
    logic [11:0] count_d;
    logic [4:0]  ones_step;
    logic [4:0]  tens_step;
    logic [4:0]  hund_step;

    always_comb begin
        ones_step = bcd_digit_inc(count_q[3:0]);
        tens_step = bcd_digit_inc(count_q[7:4]);
        hund_step = bcd_digit_inc(count_q[11:8]);
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != BCD_MAX)) begin
            // Ripple the carry upward; saturation keeps hundreds below 9 wrap.
            count_d[3:0] = ones_step[3:0];
            if (ones_step[4]) begin
                count_d[7:4] = tens_step[3:0];
                if (tens_step[4]) begin
                    count_d[11:8] = hund_step[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_referee.sv
// Game referee: decides collisions and pipe passes each frame tick,
// runs the IDLE/PLAY/HIT/OVER flow and keeps the BCD score.
module pipe_referee
    import flappy_pkg::*;
#(
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int PIPE_W    = DEF_PIPE_W,
    parameter int GAP_HALF  = DEF_GAP_HALF,
    parameter int HIT_HOLD  = DEF_HIT_HOLD,
    parameter int SCREEN_H  = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [COORD_W-1:0] pipe_x,
    input  logic [COORD_W-1:0] gap_y,
    input  logic [COORD_W-1:0] bird_y,
    output logic               freeze,
    output logic               pipe_restart,
    output logic               game_over,
    output logic               hit,
    output logic [11:0]        score_bcd,
    output logic [1:0]         state
);

    localparam int HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HIT_HOLD - 1);

    localparam logic [SUM_W-1:0] BIRD_LEFT  = SUM_W'(BIRD_X);
    localparam logic [SUM_W-1:0] BIRD_RIGHT = SUM_W'(BIRD_X + BIRD_SIZE);
    localparam logic [SUM_W-1:0] PIPE_W_S   = SUM_W'(PIPE_W);
    localparam logic [SUM_W-1:0] GAP_HALF_S = SUM_W'(GAP_HALF);
    localparam logic [SUM_W-1:0] BIRD_SZ_S  = SUM_W'(BIRD_SIZE);
    localparam logic [SUM_W-1:0] FLOOR_S    = SUM_W'(SCREEN_H);

    state_t              state_q;
    state_t              state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic                passed_q;
    logic                passed_d;
    logic                freeze_q;
    logic                freeze_d;
    logic                restart_q;
    logic                restart_d;
    logic                game_over_q;
    logic                game_over_d;
    logic                hit_q;
    logic                hit_d;
    logic                score_clear;
    logic                score_inc;
    logic                launch;

    logic [SUM_W-1:0]    pipe_left;
    logic [SUM_W-1:0]    pipe_right;
    logic [SUM_W-1:0]    bird_top;
    logic [SUM_W-1:0]    bird_bot;
    logic [SUM_W-1:0]    gap_c;
    logic [SUM_W-1:0]    gap_top;
    logic [SUM_W-1:0]    gap_bot;
    logic                overlap;
    logic                collision;
    logic                pass_ok;
    logic                clear_zone;

    // All geometry is widened to 11 bits so sums near the screen edge cannot wrap.
    assign pipe_left  = {1'b0, pipe_x};
    assign pipe_right = pipe_left + PIPE_W_S;
    assign bird_top   = {1'b0, bird_y};
    assign bird_bot   = bird_top + BIRD_SZ_S;
    assign gap_c      = {1'b0, gap_y};
    assign gap_top    = (gap_c >= GAP_HALF_S) ? (gap_c - GAP_HALF_S) : '0;
    assign gap_bot    = gap_c + GAP_HALF_S;

    assign overlap    = (pipe_left < BIRD_RIGHT) && (pipe_right > BIRD_LEFT);
    assign collision  = (overlap && ((bird_top < gap_top) || (bird_bot > gap_bot)))
                        || (bird_bot >= FLOOR_S);
    assign pass_ok    = (pipe_right <= BIRD_LEFT) && !passed_q;
    assign clear_zone = pipe_left > BIRD_RIGHT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: if (start)          state_d = ST_PLAY;
                ST_PLAY: if (collision)      state_d = ST_HIT;
                ST_HIT:  if (hold_q == '0)   state_d = ST_OVER;
                ST_OVER: if (start)          state_d = ST_PLAY;
                default:                     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        launch      = tick && start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
        hit_d       = tick && (state_q == ST_PLAY) && collision;
        restart_d   = launch;
        score_clear = launch;
        score_inc   = tick && (state_q == ST_PLAY) && !collision && pass_ok;

        hold_d = hold_q;
        if (hit_d) begin
            hold_d = HOLD_LOAD;
        end else if (tick && (state_q == ST_HIT) && (hold_q != '0)) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        // The flag re-arms once the pipe is back to the right of the bird.
        passed_d = passed_q;
        if (launch || (tick && clear_zone)) begin
            passed_d = 1'b0;
        end else if (score_inc) begin
            passed_d = 1'b1;
        end

        freeze_d    = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            passed_q    <= 1'b0;
            freeze_q    <= 1'b1;
            restart_q   <= 1'b0;
            game_over_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            passed_q    <= passed_d;
            freeze_q    <= freeze_d;
            restart_q   <= restart_d;
            game_over_q <= game_over_d;
            hit_q       <= hit_d;
        end
    end

    bcd_counter3 u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (score_inc),
        .count (score_bcd)
    );

    assign freeze       = freeze_q;
    assign pipe_restart = restart_q;
    assign game_over    = game_over_q;
    assign hit          = hit_q;
    assign state        = state_q;

endmodule
